// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and the PC tag carried alongside each I-cache request.
package cpu_pkg;

  localparam int unsigned QUEUE_DEPTH_BITS     = 3;
  localparam int unsigned MAX_OUTSTANDING_BITS = 2;
  localparam logic [31:0] RESET_PC             = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
  } fetch_tag_t;

endpackage

// File: rtl/pc_tag_fifo.sv
// Show-ahead FIFO pairing each issued request PC with its in-order response.
module pc_tag_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_tag_t push_data,
  input  logic       pop,
  output fetch_tag_t head,
  output logic       empty,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_tag_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A push against a full FIFO is refused even if a pop frees a slot the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_prefetcher.sv
// Instruction-queue write-side producer: credit-limited sequential fetch, in-order
// response forwarding, and redirect flush with stale-response discard.
module inst_fetch_prefetcher
  import cpu_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH     = 1 << QUEUE_DEPTH_BITS,
  parameter int unsigned MAX_OUTSTANDING = 1 << MAX_OUTSTANDING_BITS,
  parameter logic [31:0] RESET_PC        = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        q_pop,
  output logic        req_valid,
  output logic [31:0] req_pc,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_data,
  output logic        q_flush
);

  localparam int unsigned QW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   fetch_pc;
  logic [QW-1:0] occupancy;
  logic [QW-1:0] credits;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic          issue;
  logic          rsp_write;
  logic          rsp_drop;
  logic          occ_pop;
  fetch_tag_t    tag_head;
  fetch_tag_t    tag_push;
  logic          tag_empty;
  logic          tag_full;

  assign credits   = QW'(QUEUE_DEPTH) - occupancy - QW'(outstanding);
  assign req_valid = rst_n && !redirect_valid && (credits != '0)
                     && (outstanding < OW'(MAX_OUTSTANDING));
  assign req_pc    = fetch_pc;
  assign issue     = req_valid && req_ready;

  assign rsp_write = rst_n && rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign rsp_drop  = rsp_valid && !redirect_valid && (drop_cnt != '0);
  assign occ_pop   = q_pop && (occupancy != '0);

  assign out_valid = rsp_write;
  assign out_pc    = rsp_write ? tag_head.pc : '0;
  assign out_data  = rsp_write ? rsp_data : '0;
  assign q_flush   = rst_n && redirect_valid;
  assign tag_push  = '{pc: fetch_pc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_pc;
      occupancy   <= '0;
      outstanding <= outstanding - OW'(rsp_valid);
      drop_cnt    <= outstanding - OW'(rsp_valid);
    end else begin
      if (issue)    fetch_pc <= fetch_pc + 32'd4;
      if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      outstanding <= outstanding + OW'(issue) - OW'(rsp_valid);
      occupancy   <= occupancy + QW'(rsp_write) - QW'(occ_pop);
    end
  end

  pc_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (tag_push),
    .pop       (rsp_valid),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> (outstanding != '0) && !tag_empty);
  a_issue_into_full_tags: assert property (@(posedge clk) disable iff (!rst_n)
    issue |-> !tag_full);
  a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= QW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_inst_fetch_prefetcher.sv
// Directed bench: a queue-based I-cache stand-in answers one cycle after issue (gated by cache_en).
module tb_inst_fetch_prefetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        q_pop;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        q_flush;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        rst_drive;
  logic        cache_en;
  logic [31:0] pend[$];
  logic [31:0] iss[$];
  logic [31:0] wr_pc[$];
  logic [31:0] wr_data[$];
  logic        last_req_valid;
  logic [31:0] last_req_pc;
  logic        last_out_valid;
  logic [31:0] last_out_pc;
  logic [31:0] last_out_data;
  logic        last_flush;

  always #5 clk = ~clk;

  inst_fetch_prefetcher #(
    .QUEUE_DEPTH     (8),
    .MAX_OUTSTANDING (4),
    .RESET_PC        (32'h0040_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_pop          (q_pop),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_data       (out_data),
    .q_flush        (q_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, sample at the falling edge, then update the cache stand-in.
  task automatic cyc(input logic redir, input logic [31:0] rpc, input logic pop);
    @(posedge clk);
    #1;
    rst_n          = rst_drive;
    redirect_valid = redir;
    redirect_pc    = rpc;
    q_pop          = pop;
    rsp_valid      = cache_en && (pend.size() > 0);
    rsp_data       = '0;
    if (rsp_valid) rsp_data = ~pend[0];
    #4;
    last_req_valid = req_valid;
    last_req_pc    = req_pc;
    last_out_valid = out_valid;
    last_out_pc    = out_pc;
    last_out_data  = out_data;
    last_flush     = q_flush;
    if (rsp_valid) void'(pend.pop_front());
    if (req_valid && req_ready) begin
      pend.push_back(req_pc);
      iss.push_back(req_pc);
    end
    if (out_valid) begin
      wr_pc.push_back(out_pc);
      wr_data.push_back(out_data);
    end
  endtask

  initial begin
    int unsigned stale;
    rst_drive = 1'b0; cache_en = 1'b0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; q_pop = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;

    // Reset state
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_req_valid", 32'(last_req_valid), 0);
    chk("rst_req_pc", last_req_pc, 32'h0040_0000);
    chk("rst_out_valid", 32'(last_out_valid), 0);
    chk("rst_out_pc", last_out_pc, 0);
    chk("rst_out_data", last_out_data, 0);
    chk("rst_q_flush", 32'(last_flush), 0);

    // 1: fill from reset with a one-cycle cache and no pops
    rst_drive = 1'b1; cache_en = 1'b1;
    repeat (12) cyc(0, 0, 0);
    chk("t1_issue_count", iss.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_issue_pc", iss[i], 32'h0040_0000 + 32'(4 * i));
    chk("t1_write_count", wr_pc.size(), 8);
    chk("t1_write_pc7", wr_pc[7], 32'h0040_001C);
    chk("t1_write_data7", wr_data[7], ~32'h0040_001C);
    chk("t1_req_valid_full", 32'(last_req_valid), 0);

    // 2: queue full, one pop per cycle
    iss.delete();
    cyc(0, 0, 1);
    chk("t2_no_credit", 32'(last_req_valid), 0);
    cyc(0, 0, 1);
    chk("t2_credit_issue", 32'(last_req_valid), 1);
    chk("t2_credit_pc", last_req_pc, 32'h0040_0020);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);
    chk("t2_issue_count", iss.size(), 4);
    chk("t2_last_issue", iss[3], 32'h0040_002C);
    chk("t2_req_valid_full", 32'(last_req_valid), 0);

    // 3: four outstanding, then redirect
    iss.delete(); cache_en = 1'b0;
    repeat (5) cyc(0, 0, 1);
    chk("t3_issue_count", iss.size(), 4);
    chk("t3_issue_last", iss[3], 32'h0040_003C);
    cyc(0, 0, 0);
    chk("t3_max_outstanding", 32'(last_req_valid), 0);
    cyc(1, 32'h0040_1000, 0);
    chk("t3_flush", 32'(last_flush), 1);
    chk("t3_no_issue_redirect", 32'(last_req_valid), 0);
    wr_pc.delete(); wr_data.delete(); cache_en = 1'b1;
    cyc(0, 0, 0);
    chk("t3_flush_one_cycle", 32'(last_flush), 0);
    chk("t3_stale_dropped", 32'(last_out_valid), 0);
    repeat (15) cyc(0, 0, 0);
    chk("t3_write_count", wr_pc.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_write_pc", wr_pc[i], 32'h0040_1000 + 32'(4 * i));
    chk("t3_write_data0", wr_data[0], ~32'h0040_1000);

    // 4: redirect coinciding with a response, two outstanding
    cache_en = 1'b0;
    repeat (3) cyc(0, 0, 1);
    cache_en = 1'b1;
    cyc(1, 32'h0040_2000, 0);
    chk("t4_flush", 32'(last_flush), 1);
    chk("t4_redirect_rsp_dropped", 32'(last_out_valid), 0);
    cyc(0, 0, 0);
    chk("t4_next_rsp_dropped", 32'(last_out_valid), 0);
    chk("t4_resume_pc", last_req_pc, 32'h0040_2000);
    cyc(0, 0, 0);
    chk("t4_written", 32'(last_out_valid), 1);
    chk("t4_written_pc", last_out_pc, 32'h0040_2000);
    chk("t4_written_data", last_out_data, ~32'h0040_2000);

    // 5: second redirect inside the drop window
    cache_en = 1'b0;
    repeat (3) cyc(0, 0, 0);
    cyc(1, 32'h0040_3000, 0);
    iss.delete(); wr_pc.delete(); wr_data.delete(); cache_en = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 32'h0040_4000, 0);
    chk("t5_flush2", 32'(last_flush), 1);
    repeat (8) cyc(0, 0, 0);
    chk("t5_old_target_issued", iss[0], 32'h0040_3000);
    chk("t5_first_write", wr_pc[0], 32'h0040_4000);
    chk("t5_second_write", wr_pc[1], 32'h0040_4004);
    stale = 0;
    foreach (wr_pc[i]) if (wr_pc[i][31:12] != 20'h00404) stale++;
    chk("t5_stale_writes", stale, 0);

    // 6: reset mid-burst
    rst_drive = 1'b0; cache_en = 1'b0; pend.delete();
    cyc(1, 32'h0040_5000, 0);
    chk("t6_flush_in_reset", 32'(last_flush), 0);
    chk("t6_req_valid_in_reset", 32'(last_req_valid), 0);
    cyc(0, 0, 0);
    chk("t6_req_pc", last_req_pc, 32'h0040_0000);
    chk("t6_req_valid", 32'(last_req_valid), 0);
    chk("t6_out_valid", 32'(last_out_valid), 0);
    iss.delete(); rst_drive = 1'b1; cache_en = 1'b1;
    repeat (3) cyc(0, 0, 0);
    chk("t6_first_issue", iss[0], 32'h0040_0000);
    chk("t6_second_issue", iss[1], 32'h0040_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
